// File: rtl/imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_arbiter
// Purpose  : Owns the single port of the instruction memory. After reset it
//            stalls the CPU and streams a program image from the loader into
//            memory starting at word 0. Once the final beat is written, the
//            port is handed to CPU fetch. Single-word patch writes and
//            whole-image reloads are still accepted while running.
// Ports    : clock / reset       - system clock, synchronous active-high reset
//            i_load_*, o_load_ready   - loader beat stream (BOOT only)
//            i_patch_*, o_patch_ready - single-word patch requests (RUN only)
//            i_reload_req             - level request for a full re-load
//            i_cpu_pc, o_cpu_instruction, o_cpu_stall - CPU fetch side
//            o_mem_we/addr/wdata, i_mem_rdata - memory port
//                                       (combinational read, synchronous write)
//            o_boot_done, o_loaded_words, o_overflow - status
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int SIZE   = 110
) (
  input  logic              clock,
  input  logic              reset,
  // loader stream
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  // patch requests
  input  logic              i_patch_valid,
  input  logic [ADDR_W-1:0] i_patch_addr,
  input  logic [DATA_W-1:0] i_patch_data,
  output logic              o_patch_ready,
  // reload request
  input  logic              i_reload_req,
  // CPU fetch
  input  logic [ADDR_W-1:0] i_cpu_pc,
  output logic [DATA_W-1:0] o_cpu_instruction,
  output logic              o_cpu_stall,
  // memory port
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  // status
  output logic              o_boot_done,
  output logic [ADDR_W-1:0] o_loaded_words,
  output logic              o_overflow
);

  // Implemented depth expressed at address width so all compares are
  // unsigned and width-matched.
  localparam logic [ADDR_W-1:0] c_SIZE = ADDR_W'(SIZE);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_loaded_words;
  logic              r_overflow;
  logic              r_boot_done;

  logic w_ptr_in_range;
  logic w_patch_in_range;
  logic w_patch_accept;

  assign w_ptr_in_range   = (r_wr_ptr < c_SIZE);
  assign w_patch_in_range = (i_patch_addr < c_SIZE);
  // reload has priority: a patch arriving alongside it is refused
  assign w_patch_accept   = (r_state == ST_RUN) & i_patch_valid & ~i_reload_req;

  // --------------------------------------------------------------------------
  // Port steering and handshakes (combinational from state + requests)
  // --------------------------------------------------------------------------
  always_comb begin
    o_load_ready      = 1'b0;
    o_patch_ready     = 1'b0;
    o_cpu_stall       = 1'b1;
    o_cpu_instruction = '0;
    o_mem_we          = 1'b0;
    o_mem_addr        = i_cpu_pc;
    o_mem_wdata       = i_patch_data;

    if (r_state == ST_BOOT) begin
      // loader owns the port; CPU sees a stall and a zero instruction
      o_load_ready = 1'b1;
      o_mem_addr   = r_wr_ptr;
      o_mem_wdata  = i_load_data;
      o_mem_we     = i_load_valid & w_ptr_in_range;
    end else begin
      o_patch_ready = ~i_reload_req;
      if (i_reload_req) begin
        // leaving RUN: hold the CPU, no write this cycle
        o_cpu_stall = 1'b1;
      end else if (i_patch_valid) begin
        // patch steals the port for one cycle; out-of-range patches are
        // consumed without writing
        o_mem_addr  = i_patch_addr;
        o_mem_wdata = i_patch_data;
        o_mem_we    = w_patch_in_range;
        o_cpu_stall = 1'b1;
      end else begin
        // zero-cycle fetch pass-through
        o_cpu_stall       = 1'b0;
        o_cpu_instruction = i_mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State, write pointer and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_BOOT;
      r_wr_ptr       <= '0;
      r_loaded_words <= '0;
      r_overflow     <= 1'b0;
      r_boot_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (i_load_valid) begin
            if (w_ptr_in_range) begin
              r_wr_ptr       <= r_wr_ptr + c_ONE;
              r_loaded_words <= r_loaded_words + c_ONE;
            end else begin
              // pointer parks at SIZE; excess beats are dropped
              r_overflow <= 1'b1;
            end
            if (i_load_last) begin
              r_state     <= ST_RUN;
              r_boot_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_reload_req) begin
            r_state        <= ST_BOOT;
            r_wr_ptr       <= '0;
            r_loaded_words <= '0;
            r_overflow     <= 1'b0;
            r_boot_done    <= 1'b0;
          end else if (w_patch_accept && !w_patch_in_range) begin
            r_overflow <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign o_boot_done    = r_boot_done;
  assign o_loaded_words = r_loaded_words;
  assign o_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_arbiter
// Purpose  : Self-checking bench for imem_load_arbiter. Instance A (SIZE=110)
//            runs a directed vector table; instance B (SIZE=4) exercises the
//            overflow path with a hand-written sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_load_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- DUT A
  logic        a_reset = 1'b1, a_lv = 1'b0, a_ll = 1'b0, a_pv = 1'b0, a_rr = 1'b0;
  logic [31:0] a_ld = '0, a_pd = '0;
  logic [19:0] a_pa = '0, a_pc = '0;
  logic        a_lr, a_pr, a_stall, a_we, a_bd, a_ov;
  logic [31:0] a_ins, a_wd, a_rd;
  logic [19:0] a_addr, a_lw;
  logic [31:0] mem_a [0:255];

  assign a_rd = (a_addr < 20'd256) ? mem_a[a_addr[7:0]] : 32'h0;
  always @(posedge clock) if (a_we && a_addr < 20'd256) mem_a[a_addr[7:0]] <= a_wd;

  imem_load_arbiter #(.ADDR_W(20), .DATA_W(32), .SIZE(110)) u_a (
    .clock(clock), .reset(a_reset),
    .i_load_valid(a_lv), .i_load_data(a_ld), .i_load_last(a_ll), .o_load_ready(a_lr),
    .i_patch_valid(a_pv), .i_patch_addr(a_pa), .i_patch_data(a_pd), .o_patch_ready(a_pr),
    .i_reload_req(a_rr), .i_cpu_pc(a_pc), .o_cpu_instruction(a_ins), .o_cpu_stall(a_stall),
    .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wd), .i_mem_rdata(a_rd),
    .o_boot_done(a_bd), .o_loaded_words(a_lw), .o_overflow(a_ov)
  );

  // ---------------------------------------------------------------- DUT B
  logic        b_reset = 1'b1, b_lv = 1'b0, b_ll = 1'b0;
  logic [31:0] b_ld = '0;
  logic [19:0] b_pc = '0;
  logic        b_lr, b_pr, b_stall, b_we, b_bd, b_ov;
  logic [31:0] b_ins, b_wd, b_rd;
  logic [19:0] b_addr, b_lw;
  logic [31:0] mem_b [0:15];
  int          b_bad_writes = 0;

  assign b_rd = (b_addr < 20'd16) ? mem_b[b_addr[3:0]] : 32'h0;
  always @(posedge clock) begin
    if (b_we && b_addr < 20'd16) mem_b[b_addr[3:0]] <= b_wd;
    if (b_we && b_addr >= 20'd4) b_bad_writes <= b_bad_writes + 1;
  end

  imem_load_arbiter #(.ADDR_W(20), .DATA_W(32), .SIZE(4)) u_b (
    .clock(clock), .reset(b_reset),
    .i_load_valid(b_lv), .i_load_data(b_ld), .i_load_last(b_ll), .o_load_ready(b_lr),
    .i_patch_valid(1'b0), .i_patch_addr(20'd0), .i_patch_data(32'd0), .o_patch_ready(b_pr),
    .i_reload_req(1'b0), .i_cpu_pc(b_pc), .o_cpu_instruction(b_ins), .o_cpu_stall(b_stall),
    .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wd), .i_mem_rdata(b_rd),
    .o_boot_done(b_bd), .o_loaded_words(b_lw), .o_overflow(b_ov)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst, lv;
    logic [31:0] ld;
    logic        ll, pv;
    logic [19:0] pa;
    logic [31:0] pd;
    logic        rr;
    logic [19:0] pc;
    logic        cc;      // check combinational outputs this cycle
    logic        e_lr, e_pr, e_st;
    logic [31:0] e_ins;
    logic        e_we;
    logic [19:0] e_addr;
    logic [31:0] e_wd;
    logic        e_bd;    // registered outputs after the edge
    logic [19:0] e_lw;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    //             rst lv ld            ll pv pa  pd            rr pc  cc lr pr st ins           we addr wd            bd lw ov
    vecs.push_back('{1,0, 32'h0,        0, 0, 0,  32'h0,        0, 5,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 0, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 5,  1, 1, 0, 1, 32'h0,        0, 0,  32'h0,        0, 0, 0});
    vecs.push_back('{0,1, 32'h20000044, 0, 0, 0,  32'h0,        0, 5,  1, 1, 0, 1, 32'h0,        1, 0,  32'h20000044, 0, 1, 0});
    vecs.push_back('{0,1, 32'h1BA00000, 0, 1, 9,  32'h12345678, 1, 5,  1, 1, 0, 1, 32'h0,        1, 1,  32'h1BA00000, 0, 2, 0});
    vecs.push_back('{0,1, 32'h3C01C200, 1, 0, 0,  32'h0,        0, 5,  1, 1, 0, 1, 32'h0,        1, 2,  32'h3C01C200, 1, 3, 0});
    vecs.push_back('{0,1, 32'h0,        0, 0, 0,  32'h0,        0, 1,  1, 0, 1, 0, 32'h1BA00000, 0, 1,  32'h0,        1, 3, 0});
    vecs.push_back('{0,0, 32'h0,        0, 1, 7,  32'hDEADBEEF, 0, 1,  1, 0, 1, 1, 32'h0,        1, 7,  32'hDEADBEEF, 1, 3, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 7,  1, 0, 1, 0, 32'hDEADBEEF, 0, 7,  32'h0,        1, 3, 0});
    vecs.push_back('{0,0, 32'h0,        0, 1, 200,32'h11111111, 0, 7,  1, 0, 1, 1, 32'h0,        0, 200,32'h11111111, 1, 3, 1});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 0, 32'h20000044, 0, 0,  32'h0,        1, 3, 1});
    vecs.push_back('{0,0, 32'h0,        0, 1, 3,  32'h55555555, 1, 0,  1, 0, 0, 1, 32'h0,        0, 0,  32'h55555555, 0, 0, 0});
    vecs.push_back('{0,1, 32'hAAAA0001, 0, 0, 0,  32'h0,        0, 0,  1, 1, 0, 1, 32'h0,        1, 0,  32'hAAAA0001, 0, 1, 0});
    vecs.push_back('{1,1, 32'hAAAA0002, 0, 0, 0,  32'h0,        0, 0,  1, 1, 0, 1, 32'h0,        1, 1,  32'hAAAA0002, 0, 0, 0});
    vecs.push_back('{0,1, 32'hBBBB0001, 0, 0, 0,  32'h0,        0, 0,  1, 1, 0, 1, 32'h0,        1, 0,  32'hBBBB0001, 0, 1, 0});
    vecs.push_back('{0,1, 32'hBBBB0002, 1, 0, 0,  32'h0,        0, 0,  1, 1, 0, 1, 32'h0,        1, 1,  32'hBBBB0002, 1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 0, 32'hBBBB0001, 0, 0,  32'h0,        1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 1,  1, 0, 1, 0, 32'hBBBB0002, 0, 1,  32'h0,        1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 2,  1, 0, 1, 0, 32'h3C01C200, 0, 2,  32'h0,        1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 1, 10, 32'hCAFE0010, 0, 2,  1, 0, 1, 1, 32'h0,        1, 10, 32'hCAFE0010, 1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 1, 11, 32'hCAFE0011, 0, 2,  1, 0, 1, 1, 32'h0,        1, 11, 32'hCAFE0011, 1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 11, 1, 0, 1, 0, 32'hCAFE0011, 0, 11, 32'h0,        1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 10, 1, 0, 1, 0, 32'hCAFE0010, 0, 10, 32'h0,        1, 2, 0});
    vecs.push_back('{0,0, 32'h0,        0, 0, 0,  32'h0,        0, 7,  1, 0, 1, 0, 32'hDEADBEEF, 0, 7,  32'h0,        1, 2, 0});

    // ---- instance A: table-driven
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      a_reset = vecs[i].rst; a_lv = vecs[i].lv; a_ld = vecs[i].ld; a_ll = vecs[i].ll;
      a_pv = vecs[i].pv; a_pa = vecs[i].pa; a_pd = vecs[i].pd; a_rr = vecs[i].rr;
      a_pc = vecs[i].pc;
      #2;
      if (vecs[i].cc) begin
        check($sformatf("v%0d load_ready", i), 32'(a_lr), 32'(vecs[i].e_lr));
        check($sformatf("v%0d patch_ready", i), 32'(a_pr), 32'(vecs[i].e_pr));
        check($sformatf("v%0d cpu_stall", i), 32'(a_stall), 32'(vecs[i].e_st));
        check($sformatf("v%0d cpu_instruction", i), a_ins, vecs[i].e_ins);
        check($sformatf("v%0d mem_we", i), 32'(a_we), 32'(vecs[i].e_we));
        check($sformatf("v%0d mem_addr", i), 32'(a_addr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d mem_wdata", i), a_wd, vecs[i].e_wd);
      end
      @(posedge clock);
      #1;
      check($sformatf("v%0d boot_done", i), 32'(a_bd), 32'(vecs[i].e_bd));
      check($sformatf("v%0d loaded_words", i), 32'(a_lw), 32'(vecs[i].e_lw));
      check($sformatf("v%0d overflow", i), 32'(a_ov), 32'(vecs[i].e_ov));
    end

    // ---- instance B (SIZE=4): 6-beat load overruns the memory
    @(negedge clock);
    b_reset = 1'b1;
    @(negedge clock);
    b_reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      b_lv = 1'b1;
      b_ld = 32'hF0000000 + 32'(k);
      b_ll = (k == 6);
      #2;
      check($sformatf("B beat%0d mem_we", k), 32'(b_we), (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("B beat%0d mem_addr", k), 32'(b_addr), (k <= 4) ? 32'(k - 1) : 32'd4);
      check($sformatf("B beat%0d cpu_stall", k), 32'(b_stall), 32'd1);
      @(posedge clock);
      #1;
      check($sformatf("B beat%0d overflow", k), 32'(b_ov), (k >= 5) ? 32'd1 : 32'd0);
      check($sformatf("B beat%0d loaded_words", k), 32'(b_lw), (k < 4) ? 32'(k) : 32'd4);
      check($sformatf("B beat%0d boot_done", k), 32'(b_bd), (k == 6) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    b_lv = 1'b0;
    b_ll = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_pc = 20'(k);
      #2;
      check($sformatf("B fetch%0d instr", k), b_ins, 32'hF0000001 + 32'(k));
      check($sformatf("B fetch%0d stall", k), 32'(b_stall), 32'd0);
      @(negedge clock);
    end
    check("B writes at addr>=SIZE", 32'(b_bad_writes), 32'd0);
    check("B patch_ready in RUN", 32'(b_pr), 32'd1);
    check("B load_ready in RUN", 32'(b_lr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
